// File: rtl/sopc_pio_pkg.sv
// Shared constants for the multi-channel output PIO: register offsets,
// address split and the pulse-length field of a PULSE write.
package sopc_pio_pkg;

   localparam int CH_ADDR_W  = 3;
   localparam int REG_ADDR_W = 2;
   localparam int ADDR_W     = CH_ADDR_W + REG_ADDR_W;
   localparam int BUS_W      = 32;

   localparam logic [REG_ADDR_W-1:0] REG_DATA  = 2'd0;
   localparam logic [REG_ADDR_W-1:0] REG_SET   = 2'd1;
   localparam logic [REG_ADDR_W-1:0] REG_CLEAR = 2'd2;
   localparam logic [REG_ADDR_W-1:0] REG_PULSE = 2'd3;

   localparam int CNT_LSB = 16;
   localparam int CNT_W   = 16;

   typedef logic [CNT_W-1:0] cnt_t;

   function automatic cnt_t pulse_len(input logic [BUS_W-1:0] wd);
      return wd[CNT_LSB +: CNT_W];
   endfunction

endpackage

// File: rtl/sopc_pio_out_multi_if.sv
// Avalon-MM slave bus for the output PIO. A write is chipselect=1 with
// write_n=0; readdata is combinational and valid in the same cycle.
interface sopc_pio_out_multi_if;
   import sopc_pio_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [BUS_W-1:0]  writedata;
   logic [BUS_W-1:0]  readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/sopc_pio_pulse_ch.sv
// One channel's self-clearing pulse: MASK is held while CNT counts down to 0.
// MASK is kept at zero whenever CNT is zero, so it can be ORed straight out.
module sopc_pio_pulse_ch
   import sopc_pio_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_mask,
   input  cnt_t              i_cnt,
   output logic [DATA_W-1:0] o_mask,
   output cnt_t              o_cnt,
   output logic              o_active
);

   logic [DATA_W-1:0] r_mask;
   cnt_t              r_cnt;

   // A load always wins over the countdown, so a new write retriggers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mask <= '0;
         r_cnt  <= '0;
      end else if (i_load) begin
         r_cnt  <= i_cnt;
         r_mask <= (i_cnt == '0) ? '0 : i_mask;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - cnt_t'(1);
         if (r_cnt == cnt_t'(1)) begin
            r_mask <= '0;
         end
      end
   end

   assign o_mask   = r_mask;
   assign o_cnt    = r_cnt;
   assign o_active = (r_cnt != '0);

endmodule

// File: rtl/sopc_pio_out_multi.sv
// NUM_CH x DATA_W output PIO with DATA/SET/CLEAR per channel. Timed pulses
// (register 3, pulse_active) exist only when SOPC_PIO_PULSE_EN is defined.
module sopc_pio_out_multi
   import sopc_pio_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int NUM_CH    = 2,
   parameter int RESET_VAL = 0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   sopc_pio_out_multi_if.slave      avs,
   output logic [NUM_CH*DATA_W-1:0] out_port,
   output logic [NUM_CH-1:0]        pulse_active
);

   localparam logic [DATA_W-1:0]  RST_DATA = RESET_VAL[DATA_W-1:0];
   localparam logic [CH_ADDR_W:0] NUM_CH_V = (CH_ADDR_W+1)'(NUM_CH);

   logic [CH_ADDR_W-1:0]  w_ch;
   logic [REG_ADDR_W-1:0] w_reg;
   logic                  w_ch_ok;
   logic                  w_wr;
   logic [DATA_W-1:0]     w_wd;
   logic [BUS_W-1:0]      w_rdata;

   logic [DATA_W-1:0]     w_data [NUM_CH];
   logic [DATA_W-1:0]     w_mask [NUM_CH];
   cnt_t                  w_cnt  [NUM_CH];

   assign w_ch    = avs.address[ADDR_W-1:REG_ADDR_W];
   assign w_reg   = avs.address[REG_ADDR_W-1:0];
   assign w_ch_ok = ({1'b0, w_ch} < NUM_CH_V);
   assign w_wr    = avs.chipselect & ~avs.write_n & w_ch_ok;
   assign w_wd    = avs.writedata[DATA_W-1:0];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic              w_sel;
      logic [DATA_W-1:0] r_data;

      assign w_sel     = w_wr && (w_ch == CH_ADDR_W'(c));
      assign w_data[c] = r_data;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_data <= RST_DATA;
         end else if (w_sel) begin
            case (w_reg)
               REG_DATA:  r_data <= w_wd;
               REG_SET:   r_data <= r_data | w_wd;
               REG_CLEAR: r_data <= r_data & ~w_wd;
               default:   r_data <= r_data;
            endcase
         end
      end

`ifdef SOPC_PIO_PULSE_EN
      sopc_pio_pulse_ch #(
         .DATA_W (DATA_W)
      ) u_pulse (
         .clk      (clk),
         .reset_n  (reset_n),
         .i_load   (w_sel && (w_reg == REG_PULSE)),
         .i_mask   (w_wd),
         .i_cnt    (pulse_len(avs.writedata)),
         .o_mask   (w_mask[c]),
         .o_cnt    (w_cnt[c]),
         .o_active (pulse_active[c])
      );
`else
      assign w_mask[c]       = '0;
      assign w_cnt[c]        = '0;
      assign pulse_active[c] = 1'b0;
`endif

      // Registers only: nothing from the bus reaches the output pins.
      assign out_port[c*DATA_W +: DATA_W] = r_data | w_mask[c];
   end

   // Channels at or above NUM_CH never match, so they read back as zero.
   always_comb begin
      w_rdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_ch == CH_ADDR_W'(c)) begin
            case (w_reg)
               REG_DATA:  w_rdata = BUS_W'(w_data[c]);
               REG_PULSE: w_rdata = {w_cnt[c], (BUS_W-CNT_W)'(w_mask[c])};
               default:   w_rdata = '0;
            endcase
         end
      end
   end

   assign avs.readdata = w_rdata;

endmodule

// File: tb/tb_sopc_pio_out_multi.sv
// Bench for sopc_pio_out_multi (DATA_W=8, NUM_CH=2, RESET_VAL=0xA5): a vector
// table for register access plus hand sequences for pulses and async reset.
module tb_sopc_pio_out_multi;

   localparam int DW  = 8;
   localparam int NCH = 2;

   typedef struct {
      logic        cs;
      logic        wr;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [15:0] exp_out;
      logic [31:0] exp_rd;
   } vec_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NCH*DW-1:0] out_port;
   logic [NCH-1:0]    pulse_active;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] exp_out_q[$];
   logic [31:0] exp_rd_q[$];

   vec_t vecs[22];

   sopc_pio_out_multi_if bus ();

   sopc_pio_out_multi #(
      .DATA_W    (DW),
      .NUM_CH    (NCH),
      .RESET_VAL (8'hA5)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .avs          (bus),
      .out_port     (out_port),
      .pulse_active (pulse_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      logic [15:0] e_out;
      logic [31:0] e_rd;
      @(negedge clk);
      bus.chipselect = v.cs;
      bus.write_n    = ~v.wr;
      bus.address    = v.addr;
      bus.writedata  = v.wdata;
      exp_out_q.push_back(v.exp_out);
      exp_rd_q.push_back(v.exp_rd);
      #1;
      e_rd = exp_rd_q.pop_front();
      check($sformatf("vec%0d readdata", idx), bus.readdata, e_rd);
      @(posedge clk);
      #1;
      e_out = exp_out_q.pop_front();
      check($sformatf("vec%0d out_port", idx), 32'(out_port), 32'(e_out));
      check($sformatf("vec%0d pulse_active", idx), 32'(pulse_active), 32'd0);
   endtask

   task automatic wr(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.address    = addr;
      bus.writedata  = data;
      @(posedge clk);
      #1;
      bus.write_n    = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n        = 1'b0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.address    = '0;
      bus.writedata  = '0;

      vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,         16'hA5A5, 32'hA5};
      vecs[1]  = '{1'b1, 1'b0, 5'd1,  32'h0,         16'hA5A5, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, 5'd2,  32'h0,         16'hA5A5, 32'h0};
      vecs[3]  = '{1'b1, 1'b0, 5'd3,  32'h0,         16'hA5A5, 32'h0};
      vecs[4]  = '{1'b1, 1'b0, 5'd4,  32'h0,         16'hA5A5, 32'hA5};
      vecs[5]  = '{1'b1, 1'b0, 5'd5,  32'h0,         16'hA5A5, 32'h0};
      vecs[6]  = '{1'b1, 1'b0, 5'd6,  32'h0,         16'hA5A5, 32'h0};
      vecs[7]  = '{1'b1, 1'b0, 5'd7,  32'h0,         16'hA5A5, 32'h0};
      vecs[8]  = '{1'b1, 1'b1, 5'd4,  32'h3C,        16'h3CA5, 32'hA5};
      vecs[9]  = '{1'b1, 1'b1, 5'd5,  32'h03,        16'h3FA5, 32'h0};
      vecs[10] = '{1'b1, 1'b1, 5'd6,  32'h30,        16'h0FA5, 32'h0};
      vecs[11] = '{1'b1, 1'b0, 5'd4,  32'h0,         16'h0FA5, 32'h0F};
      vecs[12] = '{1'b1, 1'b1, 5'd28, 32'hFF,        16'h0FA5, 32'h0};
      vecs[13] = '{1'b1, 1'b0, 5'd28, 32'h0,         16'h0FA5, 32'h0};
      vecs[14] = '{1'b1, 1'b0, 5'd31, 32'h0,         16'h0FA5, 32'h0};
      vecs[15] = '{1'b0, 1'b1, 5'd0,  32'h0,         16'h0FA5, 32'hA5};
      vecs[16] = '{1'b1, 1'b1, 5'd0,  32'hFFFFFF12,  16'h0F12, 32'hA5};
      vecs[17] = '{1'b1, 1'b0, 5'd0,  32'h0,         16'h0F12, 32'h12};
      vecs[18] = '{1'b1, 1'b1, 5'd2,  32'hFFFFFFFF,  16'h0F00, 32'h0};
      vecs[19] = '{1'b1, 1'b1, 5'd1,  32'h80,        16'h0F80, 32'h0};
      vecs[20] = '{1'b1, 1'b1, 5'd2,  32'h80,        16'h0F00, 32'h0};
      vecs[21] = '{1'b1, 1'b1, 5'd29, 32'hFF,        16'h0F00, 32'h0};

      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 22; i++) begin
         apply_vec(vecs[i], i);
      end
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;

`ifdef SOPC_PIO_PULSE_EN
      // Length-5 pulse on ch0 bit 7: expectations for the whole window queued up front.
      wr(5'd3, 32'h0005_0080);
      for (int i = 0; i < 7; i++) begin
         exp_out_q.push_back((i < 5) ? 16'h0F80 : 16'h0F00);
         exp_rd_q.push_back((i < 5) ? {16'(5 - i), 16'h0080} : 32'h0);
      end
      for (int i = 0; i < 7; i++) begin
         if (i > 0) step();
         check($sformatf("pulse5 out c%0d", i), 32'(out_port), 32'(exp_out_q.pop_front()));
         check($sformatf("pulse5 rd c%0d", i), bus.readdata, exp_rd_q.pop_front());
         check($sformatf("pulse5 act c%0d", i), 32'(pulse_active), (i < 5) ? 32'd1 : 32'd0);
      end

      // Retrigger a long pulse with a short one and a different mask.
      wr(5'd3, 32'h000A_0040);
      check("retrig first out", 32'(out_port), 32'h0F40);
      step();
      step();
      wr(5'd3, 32'h0002_0001);
      check("retrig new out", 32'(out_port), 32'h0F01);
      check("retrig new rd", bus.readdata, 32'h0002_0001);
      step();
      check("retrig last out", 32'(out_port), 32'h0F01);
      check("retrig last act", 32'(pulse_active), 32'd1);
      step();
      check("retrig end out", 32'(out_port), 32'h0F00);
      check("retrig end act", 32'(pulse_active), 32'd0);

      // Length-0 write aborts an active pulse.
      wr(5'd3, 32'h000A_00FF);
      check("abort pre out", 32'(out_port), 32'h0FFF);
      step();
      wr(5'd3, 32'h0000_00FF);
      check("abort out", 32'(out_port), 32'h0F00);
      check("abort act", 32'(pulse_active), 32'd0);
      check("abort rd", bus.readdata, 32'h0);

      // DATA and CLEAR writes mid-pulse leave the countdown alone.
      wr(5'd3, 32'h0003_0080);
      wr(5'd0, 32'h01);
      check("mid data out", 32'(out_port), 32'h0F81);
      check("mid data rd", bus.readdata, 32'h01);
      bus.address = 5'd3;
      #1;
      check("mid cnt rd", bus.readdata, 32'h0002_0080);
      wr(5'd2, 32'h01);
      check("mid clr out", 32'(out_port), 32'h0F80);
      step();
      check("mid end out", 32'(out_port), 32'h0F00);
      check("mid end act", 32'(pulse_active), 32'd0);
`else
      // Without pulse support register 3 is inert.
      wr(5'd3, 32'h0005_0080);
      check("nopulse out", 32'(out_port), 32'h0F00);
      check("nopulse act", 32'(pulse_active), 32'd0);
      check("nopulse rd", bus.readdata, 32'h0);
      step();
      check("nopulse out2", 32'(out_port), 32'h0F00);
`endif

      // Asynchronous reset in the middle of a cycle.
      wr(5'd4, 32'h77);
      check("pre-reset out", 32'(out_port), 32'h7700);
`ifdef SOPC_PIO_PULSE_EN
      wr(5'd7, 32'h0064_0080);
      check("long pulse out", 32'(out_port), 32'hF700);
      check("long pulse act", 32'(pulse_active), 32'd2);
`endif
      step();
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("async reset out", 32'(out_port), 32'hA5A5);
      check("async reset act", 32'(pulse_active), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      bus.address    = 5'd7;
      #1;
      check("post reset reg3", bus.readdata, 32'h0);
      bus.address = 5'd4;
      #1;
      check("post reset data", bus.readdata, 32'hA5);
      step();
      check("post reset hold", 32'(out_port), 32'hA5A5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sopc_pio_out_multi.md
# sopc_pio_out_multi

Parametrised multi-channel Avalon-MM output PIO for the SOPC system, successor to the single 8-bit output port. It provides NUM_CH independent output channels of DATA_W bits, each with direct write, atomic bit set and bit clear, and an optional self-clearing timed pulse per channel. It sits on the CPU's Avalon-MM interconnect as a zero-wait-state slave and drives counter-control strobes and enables in the fabric.

## Interface
Parameters:
- DATA_W, 8: bits per channel; legal range 1..16.
- NUM_CH, 2: number of channels; legal range 1..8.
- RESET_VAL, 0: reset value of every channel's DATA register, truncated to DATA_W.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  5  word address; [4:2] is the channel, [1:0] is the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational with zero wait states; unused upper bits are 0.
- out_port  out  NUM_CH*DATA_W  channel outputs; channel c occupies [c*DATA_W +: DATA_W].
- pulse_active  out  NUM_CH  high while channel c has a pulse in progress.

## Operation
- A write occurs when chipselect=1 and write_n=0. When chipselect=0 there is no effect and readdata is still driven.
- Per-channel register map (reg = address[1:0]):
  - 0 DATA (RW): write sets DATA to writedata[DATA_W-1:0]. Read returns DATA.
  - 1 SET (W1S): DATA becomes DATA | writedata[DATA_W-1:0]. Reads return 0.
  - 2 CLEAR (W1C): DATA becomes DATA & ~writedata[DATA_W-1:0]. Reads return 0.
  - 3 PULSE: write loads MASK from writedata[DATA_W-1:0] and CNT from writedata[31:16]. Read returns {CNT, zero pad, MASK}.
- out_port for channel c = DATA | MASK, where MASK counts only while CNT≠0. The OR of two registers is the only logic on the output; no path runs from the bus to out_port.
- Pulse counter:
  - While CNT>0, CNT decrements by 1 every cycle.
  - On the edge where CNT goes from 1 to 0, MASK clears.
  - pulse_active = (CNT≠0).
- Pulse boundary conditions:
  - A PULSE write with length 0 clears MASK and CNT, which aborts any active pulse.
  - A PULSE write during an active pulse replaces both MASK and CNT. This retriggers the pulse; it does not extend the old one.
  - CNT saturates at 0 and never wraps.
  - Writing DATA, SET or CLEAR during a pulse changes DATA only; the pulse continues unchanged.
- Addresses with channel ≥ NUM_CH: writes are ignored and reads return 0.
- Reset:
  - DATA = RESET_VAL, MASK = 0, CNT = 0.
  - Therefore out_port = RESET_VAL replicated per channel, and pulse_active = 0.
  - Asserting reset mid-pulse aborts the pulse immediately.

## Timing
- A write accepted at edge k is visible on out_port and readdata after edge k.
- Pulse of length L written at edge k: MASK bits are high on out_port for exactly L cycles, from after edge k until edge k+L. pulse_active follows the same window.
- Read latency is 0 cycles; readdata depends combinationally on address and the registers.
- Every register update happens on the rising edge of clk.

## Configuration
- SOPC_PIO_PULSE_EN defined: the PULSE register, the per-channel counters and pulse_active are implemented as described above.
- SOPC_PIO_PULSE_EN undefined: no MASK or CNT storage exists. Register 3 reads 0 and ignores writes, pulse_active is tied to 0, and out_port = DATA.

## Structure
- Package sopc_pio_pkg holds:
  - register offset constants REG_DATA=0, REG_SET=1, REG_CLEAR=2, REG_PULSE=3;
  - the CNT field position constants (lsb 16, width 16);
  - the channel-address width constant (3).
- Sub-module sopc_pio_pulse_ch holds one channel's MASK and CNT, takes a load strobe, and outputs mask and active. It is instantiated NUM_CH times in a generate loop, only under SOPC_PIO_PULSE_EN.
- The top level holds the DATA registers, address decode and read mux.

## Test plan
- Reset with RESET_VAL=8'hA5, NUM_CH=2 → out_port=16'hA5A5, pulse_active=0, every readdata=0 except DATA reads (0xA5).
- Write DATA ch1=0x3C, then SET 0x03, then CLEAR 0x30 → ch1 out_port reads 0x3C, then 0x3F, then 0x0F on the cycles after each write; ch0 is unchanged.
- PULSE ch0 with writedata=0x0005_0080 and DATA=0 → out_port[7] high for exactly 5 cycles, pulse_active[0] has the same window, and reads of reg 3 return CNT counting 5,4,3,2,1.
- PULSE len 10, then retrigger at cycle 3 with len 2 and mask 0x01 → mask switches to 0x01 and the pulse ends 2 cycles after the retrigger; a len-0 write mid-pulse aborts it on the next cycle.
- Assert reset_n at cycle 2 of a 100-cycle pulse → out_port returns to RESET_VAL immediately (asynchronously) and pulse_active=0.
- Write/read channel address 7 with NUM_CH=2, plus a write with chipselect=0 → no register changes, and readdata=0 for the channel-7 read; rebuild without SOPC_PIO_PULSE_EN and confirm reg 3 reads 0 and PULSE writes have no effect.
